// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyphs, the
// decimal-point bit position and the active-low "everything off" patterns.
package seg_pkg;

  localparam int SEG_DP  = 7;
  localparam int MAX_DIG = 8;

  // Active-low off patterns for the segment bus and the digit selects.
  localparam logic [7:0]         SEG_OFF     = 8'hFF;
  localparam logic [MAX_DIG-1:0] DIG_OFF_ALL = '1;

  // Active-high glyphs, bit order g..a.
  localparam logic [6:0] HEX_0 = 7'h3F;
  localparam logic [6:0] HEX_1 = 7'h06;
  localparam logic [6:0] HEX_2 = 7'h5B;
  localparam logic [6:0] HEX_3 = 7'h4F;
  localparam logic [6:0] HEX_4 = 7'h66;
  localparam logic [6:0] HEX_5 = 7'h6D;
  localparam logic [6:0] HEX_6 = 7'h7D;
  localparam logic [6:0] HEX_7 = 7'h07;
  localparam logic [6:0] HEX_8 = 7'h7F;
  localparam logic [6:0] HEX_9 = 7'h6F;
  localparam logic [6:0] HEX_A = 7'h77;
  localparam logic [6:0] HEX_B = 7'h7C;
  localparam logic [6:0] HEX_C = 7'h39;
  localparam logic [6:0] HEX_D = 7'h5E;
  localparam logic [6:0] HEX_E = 7'h79;
  localparam logic [6:0] HEX_F = 7'h71;

  function automatic logic [6:0] hexseg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return HEX_0;
      4'h1: return HEX_1;
      4'h2: return HEX_2;
      4'h3: return HEX_3;
      4'h4: return HEX_4;
      4'h5: return HEX_5;
      4'h6: return HEX_6;
      4'h7: return HEX_7;
      4'h8: return HEX_8;
      4'h9: return HEX_9;
      4'hA: return HEX_A;
      4'hB: return HEX_B;
      4'hC: return HEX_C;
      4'hD: return HEX_D;
      4'hE: return HEX_E;
      default: return HEX_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational glyph decoder: one nibble plus decimal point to an
// active-high 8-bit segment vector {dp, g..a}.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Look up the glyph and merge in the decimal point.
  always_comb begin
    seg         = {1'b0, hexseg(nibble)};
    seg[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multi-digit seven-segment scan driver. Double-buffered display data is
// swapped only at frame wrap; each digit slot opens with a dark guard
// interval to suppress ghosting. All outputs are registered.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIG      = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYC    = 2000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [4*NUM_DIG-1:0]   digits,
  input  logic [NUM_DIG-1:0]     dp_mask,
  input  logic [NUM_DIG-1:0]     blank_mask,
  input  logic [NUM_DIG-1:0]     blink_mask,
  output logic [NUM_DIG-1:0]     DIG,
  output logic [7:0]             Y,
  output logic                   frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]      PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]      GUARD_END  = PW'(GUARD_CYC);
  localparam logic [IW-1:0]      IDX_LAST   = IW'(NUM_DIG - 1);
  localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIG-1:0] DIG_OFF    = DIG_OFF_ALL[NUM_DIG-1:0];

  typedef struct packed {
    logic [4*NUM_DIG-1:0] digits;
    logic [NUM_DIG-1:0]   dp;
    logic [NUM_DIG-1:0]   blank;
    logic [NUM_DIG-1:0]   blink;
  } disp_t;

  // Blank everything until a real load has been promoted to the active set.
  localparam disp_t DISP_RST = '{digits: '0, dp: '0, blank: '1, blink: '0};

  logic [PW-1:0]      pre_cnt_q, pre_cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               pending_q, pending_d;
  disp_t              shd_q, shd_d;
  disp_t              act_q, act_d;
  logic [NUM_DIG-1:0] dig_q, dig_d;
  logic [7:0]         y_q, y_d;
  logic               frame_done_q, frame_done_d;

  disp_t              in_disp;
  logic               tick, wrap, guard, digit_off;
  logic [3:0]         cur_nibble;
  logic               cur_dp, cur_blank, cur_blink;
  logic [NUM_DIG-1:0] dig_sel;
  logic [7:0]         seg_on;

  assign in_disp = '{digits: digits, dp: dp_mask, blank: blank_mask, blink: blink_mask};

  // Pick the active-buffer fields for the digit currently being scanned.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b1;
    cur_blink  = 1'b0;
    dig_sel    = DIG_OFF;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nibble = act_q.digits[4*i +: 4];
        cur_dp     = act_q.dp[i];
        cur_blank  = act_q.blank[i];
        cur_blink  = act_q.blink[i];
        dig_sel[i] = 1'b0;
      end
    end
  end

  seg_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .seg    (seg_on)
  );

  // Next-state logic: scan counters, blink timer, buffer swap and output patterns.
  always_comb begin
    tick = (pre_cnt_q == PRE_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    pre_cnt_d = tick ? '0 : pre_cnt_q + PW'(1);

    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    // A load always lands in shadow; a load coinciding with wrap also goes
    // straight to active so it is neither lost nor delayed a full frame.
    shd_d     = shd_q;
    act_d     = act_q;
    pending_d = pending_q;
    if (load) begin
      shd_d     = in_disp;
      pending_d = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        act_d     = in_disp;
        pending_d = 1'b0;
      end else if (pending_q) begin
        act_d     = shd_q;
        pending_d = 1'b0;
      end
    end

    guard     = (pre_cnt_q < GUARD_END);
    digit_off = cur_blank || (cur_blink && blink_phase_q);
    dig_d     = DIG_OFF;
    y_d       = SEG_OFF;
    if (!guard && !digit_off) begin
      dig_d = dig_sel;
      y_d   = ~seg_on;
    end

    frame_done_d = wrap;
  end

  // State and output registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the display buffers are reset too, so the panel is provably dark before the first load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_q     <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pending_q     <= 1'b0;
      shd_q         <= DISP_RST;
      act_q         <= DISP_RST;
      dig_q         <= DIG_OFF;
      y_q           <= SEG_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pending_q     <= pending_d;
      shd_q         <= shd_d;
      act_q         <= act_d;
      dig_q         <= dig_d;
      y_q           <= y_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign DIG        = dig_q;
  assign Y          = y_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multi-digit seven-segment scan driver. It is the next generation of the vending-machine display path.
- Takes NUM_DIG hex nibbles with per-digit decimal-point, blank and blink masks, and time-multiplexes them onto a common-segment, per-digit-select display.
- Display data is double-buffered and swapped only at frame boundaries, so there is no tearing.
- An anti-ghosting guard interval precedes every digit slot.
- Sits between the control FSM (which issues load) and the board pins.

Parameters:
- NUM_DIG, 8: number of digits, legal range 1..8.
- SCAN_DIV, 100000: clk cycles per digit slot, minimum 2.
- GUARD_CYC, 2000: cycles at the start of each slot with all digits off. Must be less than SCAN_DIV.
- BLINK_FRAMES, 64: frames per blink half-period, minimum 1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset. Asynchronous, active-low.
- load, in, 1: single-cycle strobe that captures digits and the three masks.
- digits, in, 4*NUM_DIG: hex value per digit; digit i is bits [4i+3:4i].
- dp_mask, in, NUM_DIG: 1 lights the decimal point of digit i.
- blank_mask, in, NUM_DIG: 1 forces digit i dark.
- blink_mask, in, NUM_DIG: 1 makes digit i blink.
- DIG, out, NUM_DIG: digit select, active-low; DIG[i]=0 enables digit i.
- Y, out, 8: segments, active-low. Y[0..6]=a..g, Y[7]=dp.
- frame_done, out, 1: one-cycle pulse at each frame wrap.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, also mid-frame):
  - pre_cnt=0, idx=0, blink_cnt=0, blink_phase=0, pending=0.
  - Shadow and active digits/dp/blink = 0; shadow and active blank = all ones, so the display is dark until the first load reaches active.
  - DIG = all ones, Y = 8'hFF, frame_done = 0.
- Prescaler:
  - pre_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted when pre_cnt==SCAN_DIV-1.
- Digit index:
  - On tick, idx increments; idx==NUM_DIG-1 wraps to 0.
  - wrap = tick and idx==NUM_DIG-1. With NUM_DIG=1, every tick is a wrap.
- frame_done:
  - Registered; high for exactly the one cycle after wrap.
  - Period is NUM_DIG*SCAN_DIV cycles.
- Blink:
  - On wrap, blink_cnt increments. When it reaches BLINK_FRAMES-1 it clears to 0 and blink_phase toggles.
  - phase=1 darkens every digit whose active blink_mask bit is set.
- Buffering:
  - load writes inputs into shadow and sets pending.
  - On wrap with pending=1: shadow copies to active and pending clears.
  - load and wrap in the same cycle: inputs go directly to both shadow and active, and pending clears.
  - load with no wrap overwrites shadow (last load wins).
  - load is never lost and never applied mid-frame.
- Output generation (registered, one-cycle latency from pre_cnt/idx):
  - guard is asserted when pre_cnt<GUARD_CYC. During guard: DIG = all ones, Y = 8'hFF.
  - Digit i = idx is off when active blank[i]=1, or when blink[i]=1 and blink_phase=1. Off means DIG = all ones and Y = 8'hFF.
  - Otherwise DIG has only bit idx low, and Y = ~{dp[i], hexseg(nibble i)}.
- hexseg values (g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
- Width rules:
  - pre_cnt width is $clog2(SCAN_DIV); idx width is max(1, $clog2(NUM_DIG)); blink_cnt width is max(1, $clog2(BLINK_FRAMES)).
  - All comparisons are exact equality; no counter may exceed its terminal value.
- No combinational path from any input to any output.

Decomposition:
- Package seg_pkg holds:
  - the 16 hex segment constants;
  - SEG_DP=7;
  - the active-low off patterns: SEG_OFF=8'hFF, and the DIG off pattern (all ones of NUM_DIG width).
- One combinational sub-module, seg_hex_decode, maps 4-bit nibble plus dp to the 8-bit active-high segment vector. It is instantiated once on the muxed nibble.
- Counters, buffering and output registers stay in the top.

Test Plan (NUM_DIG=4, SCAN_DIV=4, GUARD_CYC=1, BLINK_FRAMES=2):
- Reset, no load → DIG=4'hF and Y=8'hFF for 64 cycles; frame_done pulses every 16 cycles.
- Load digits=16'h1234, masks=0 mid-frame → still dark until the next wrap. Next frame:
  - digit0: DIG=4'b1110, Y=8'h99 for 3 cycles after 1 guard cycle.
  - digit1: DIG=4'b1101, Y=8'hB0.
- dp_mask=4'b0001 with digit0=8 → Y=8'h00. blank_mask=4'b0010 → digit1 slot shows DIG=4'hF.
- blink_mask=4'b0100 → digit2 is lit for 2 frames, dark for 2 frames, repeating; other digits are unaffected.
- load asserted in the wrap cycle with digits=16'hFFFF → the next frame shows F (Y=8'h8E) on all digits. A second load later in that frame → applied only at the following wrap.
- Assert rst mid-slot → DIG=all ones and Y=8'hFF the same cycle. After release, idx=0 and the display is dark until a new load.
